// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: forwards EX/MEM results into the captured operands, detects load-use hazards,
// and honours hold/flush. Defining ID_EX_STATS_EN adds saturating bubble_count/hold_count outputs.
module id_ex_stage #(
   parameter int DATA_W = 16,
   parameter int REG_AW = 4,
   parameter int OP_W   = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              id_valid,
   output logic              id_ready,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic [DATA_W-1:0] id_reg1,
   input  logic [DATA_W-1:0] id_reg2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [OP_W-1:0]   id_op,
   input  logic              id_regwrite,
   input  logic              id_memread,
   input  logic              id_memwrite,
   input  logic              ex_hold,
   input  logic              flush,
   input  logic [REG_AW-1:0] fwd_ex_rd,
   input  logic              fwd_ex_regwrite,
   input  logic [DATA_W-1:0] fwd_ex_result,
   input  logic [REG_AW-1:0] fwd_mem_rd,
   input  logic              fwd_mem_regwrite,
   input  logic [DATA_W-1:0] fwd_mem_result,
   output logic              ex_valid,
   output logic [REG_AW-1:0] ex_rd,
   output logic [OP_W-1:0]   ex_op,
   output logic [DATA_W-1:0] ex_a,
   output logic [DATA_W-1:0] ex_b,
   output logic [DATA_W-1:0] ex_imm,
   output logic              ex_regwrite,
   output logic              ex_memread,
   output logic              ex_memwrite,
`ifdef ID_EX_STATS_EN
   output logic [15:0]       bubble_count,
   output logic [15:0]       hold_count,
`endif
   output logic              hazard
);

   logic              ex_valid_q, ex_valid_d;
   logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
   logic [OP_W-1:0]   ex_op_q, ex_op_d;
   logic [DATA_W-1:0] ex_a_q, ex_a_d;
   logic [DATA_W-1:0] ex_b_q, ex_b_d;
   logic [DATA_W-1:0] ex_imm_q, ex_imm_d;
   logic              ex_regwrite_q, ex_regwrite_d;
   logic              ex_memread_q, ex_memread_d;
   logic              ex_memwrite_q, ex_memwrite_d;

   // EX result wins over MEM; register 0 always reads as zero.
   function automatic logic [DATA_W-1:0] forward_operand(input logic [REG_AW-1:0] src,
                                                         input logic [DATA_W-1:0] reg_val,
                                                         input logic              ex_rw,
                                                         input logic [REG_AW-1:0] ex_dst,
                                                         input logic [DATA_W-1:0] ex_res,
                                                         input logic              mem_rw,
                                                         input logic [REG_AW-1:0] mem_dst,
                                                         input logic [DATA_W-1:0] mem_res);
      if (src == '0)                      return '0;
      else if (ex_rw && ex_dst == src)    return ex_res;
      else if (mem_rw && mem_dst == src)  return mem_res;
      else                                return reg_val;
   endfunction

   always_comb begin
      hazard = ex_valid_q && ex_memread_q && ex_regwrite_q && (ex_rd_q != '0) && id_valid &&
               ((id_use_rs1 && id_rs1 == ex_rd_q) || (id_use_rs2 && id_rs2 == ex_rd_q));
      id_ready = !ex_hold && !hazard && !reset;
   end

   always_comb begin
      ex_valid_d    = 1'b0;
      ex_rd_d       = '0;
      ex_op_d       = '0;
      ex_a_d        = '0;
      ex_b_d        = '0;
      ex_imm_d      = '0;
      ex_regwrite_d = 1'b0;
      ex_memread_d  = 1'b0;
      ex_memwrite_d = 1'b0;
      if (ex_hold) begin
         ex_valid_d    = ex_valid_q;
         ex_rd_d       = ex_rd_q;
         ex_op_d       = ex_op_q;
         ex_a_d        = ex_a_q;
         ex_b_d        = ex_b_q;
         ex_imm_d      = ex_imm_q;
         ex_regwrite_d = ex_regwrite_q;
         ex_memread_d  = ex_memread_q;
         ex_memwrite_d = ex_memwrite_q;
      end else if (!flush && !hazard && id_valid) begin
         ex_valid_d    = 1'b1;
         ex_rd_d       = id_rd;
         ex_op_d       = id_op;
         ex_a_d        = forward_operand(id_rs1, id_reg1, fwd_ex_regwrite, fwd_ex_rd, fwd_ex_result,
                                         fwd_mem_regwrite, fwd_mem_rd, fwd_mem_result);
         ex_b_d        = forward_operand(id_rs2, id_reg2, fwd_ex_regwrite, fwd_ex_rd, fwd_ex_result,
                                         fwd_mem_regwrite, fwd_mem_rd, fwd_mem_result);
         ex_imm_d      = id_imm;
         ex_regwrite_d = id_regwrite;
         ex_memread_d  = id_memread;
         ex_memwrite_d = id_memwrite;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ex_valid_q    <= 1'b0;
         ex_rd_q       <= '0;
         ex_op_q       <= '0;
         ex_a_q        <= '0;
         ex_b_q        <= '0;
         ex_imm_q      <= '0;
         ex_regwrite_q <= 1'b0;
         ex_memread_q  <= 1'b0;
         ex_memwrite_q <= 1'b0;
      end else begin
         ex_valid_q    <= ex_valid_d;
         ex_rd_q       <= ex_rd_d;
         ex_op_q       <= ex_op_d;
         ex_a_q        <= ex_a_d;
         ex_b_q        <= ex_b_d;
         ex_imm_q      <= ex_imm_d;
         ex_regwrite_q <= ex_regwrite_d;
         ex_memread_q  <= ex_memread_d;
         ex_memwrite_q <= ex_memwrite_d;
      end
   end

   assign ex_valid    = ex_valid_q;
   assign ex_rd       = ex_rd_q;
   assign ex_op       = ex_op_q;
   assign ex_a        = ex_a_q;
   assign ex_b        = ex_b_q;
   assign ex_imm      = ex_imm_q;
   assign ex_regwrite = ex_regwrite_q;
   assign ex_memread  = ex_memread_q;
   assign ex_memwrite = ex_memwrite_q;

`ifdef ID_EX_STATS_EN
   logic [15:0] bubble_count_q, bubble_count_d;
   logic [15:0] hold_count_q, hold_count_d;

   // Any non-hold edge that does not capture an instruction counts as a bubble.
   always_comb begin
      bubble_count_d = bubble_count_q;
      hold_count_d   = hold_count_q;
      if (ex_hold) begin
         if (hold_count_q != 16'hFFFF) hold_count_d = hold_count_q + 16'd1;
      end else if (flush || hazard || !id_valid) begin
         if (bubble_count_q != 16'hFFFF) bubble_count_d = bubble_count_q + 16'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         bubble_count_q <= '0;
         hold_count_q   <= '0;
      end else begin
         bubble_count_q <= bubble_count_d;
         hold_count_q   <= hold_count_d;
      end
   end

   assign bubble_count = bubble_count_q;
   assign hold_count   = hold_count_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a driver pushes model predictions into queues, two monitors pop and compare.
// Also exercises the ID_EX_STATS_EN counters when that macro is defined.
module tb_id_ex_stage;

   typedef struct {
      logic        reset, id_valid, use1, use2, rw, mr, mw, hold, flush;
      logic [3:0]  rs1, rs2, rd, op, fwd_ex_rd, fwd_mem_rd;
      logic        fwd_ex_rw, fwd_mem_rw;
      logic [15:0] reg1, reg2, imm, fwd_ex_res, fwd_mem_res;
   } stim_t;

   typedef struct {
      logic        valid, rw, mr, mw;
      logic [3:0]  rd, op;
      logic [15:0] a, b, imm;
      int          bubbles, holds;
   } ex_model_t;

   typedef struct {
      logic hazard, ready;
   } comb_exp_t;

   logic        clock = 1'b0;
   logic        reset, id_valid, id_ready, id_use_rs1, id_use_rs2;
   logic [3:0]  id_rs1, id_rs2, id_rd, id_op, fwd_ex_rd, fwd_mem_rd, ex_rd, ex_op;
   logic [15:0] id_reg1, id_reg2, id_imm, fwd_ex_result, fwd_mem_result, ex_a, ex_b, ex_imm;
   logic        id_regwrite, id_memread, id_memwrite, ex_hold, flush;
   logic        fwd_ex_regwrite, fwd_mem_regwrite;
   logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, hazard;
`ifdef ID_EX_STATS_EN
   logic [15:0] bubble_count, hold_count;
`endif

   int checks = 0;
   int failures = 0;
   ex_model_t model;
   bit known = 0;
   ex_model_t exQ[$];
   comb_exp_t combQ[$];

   id_ex_stage dut (
      .clock(clock), .reset(reset), .id_valid(id_valid), .id_ready(id_ready),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .id_reg1(id_reg1), .id_reg2(id_reg2), .id_rd(id_rd), .id_imm(id_imm), .id_op(id_op),
      .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
      .ex_hold(ex_hold), .flush(flush),
      .fwd_ex_rd(fwd_ex_rd), .fwd_ex_regwrite(fwd_ex_regwrite), .fwd_ex_result(fwd_ex_result),
      .fwd_mem_rd(fwd_mem_rd), .fwd_mem_regwrite(fwd_mem_regwrite), .fwd_mem_result(fwd_mem_result),
      .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_op(ex_op), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
      .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
`ifdef ID_EX_STATS_EN
      .bubble_count(bubble_count), .hold_count(hold_count),
`endif
      .hazard(hazard)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic stim_t idle();
      stim_t s;
      s = '{default: '0};
      return s;
   endfunction

   function automatic logic [15:0] operandValue(input logic [3:0] idx, input logic [15:0] regv, input stim_t s);
      if (idx == 0) return 16'h0000;
      if (s.fwd_ex_rw && s.fwd_ex_rd == idx) return s.fwd_ex_res;
      if (s.fwd_mem_rw && s.fwd_mem_rd == idx) return s.fwd_mem_res;
      return regv;
   endfunction

   // Drive one cycle at the falling edge and record what the model says should follow.
   task automatic applyStimulus(input stim_t s);
      logic hz;
      ex_model_t cleared;
      @(negedge clock);
      reset = s.reset; id_valid = s.id_valid; id_rs1 = s.rs1; id_rs2 = s.rs2;
      id_use_rs1 = s.use1; id_use_rs2 = s.use2; id_reg1 = s.reg1; id_reg2 = s.reg2;
      id_rd = s.rd; id_imm = s.imm; id_op = s.op; id_regwrite = s.rw; id_memread = s.mr;
      id_memwrite = s.mw; ex_hold = s.hold; flush = s.flush;
      fwd_ex_rd = s.fwd_ex_rd; fwd_ex_regwrite = s.fwd_ex_rw; fwd_ex_result = s.fwd_ex_res;
      fwd_mem_rd = s.fwd_mem_rd; fwd_mem_regwrite = s.fwd_mem_rw; fwd_mem_result = s.fwd_mem_res;
      hz = 1'b0;
      if (known) begin
         hz = model.valid && model.mr && model.rw && model.rd != 0 && s.id_valid &&
              ((s.use1 && s.rs1 == model.rd) || (s.use2 && s.rs2 == model.rd));
         combQ.push_back('{hazard: hz, ready: !s.hold && !hz && !s.reset});
      end
      cleared = '{default: '0};
      cleared.bubbles = model.bubbles;
      cleared.holds = model.holds;
      if (s.reset) begin
         model = '{default: '0};
         known = 1;
      end else if (s.hold) begin
         if (model.holds < 65535) model.holds++;
      end else if (s.flush || hz || !s.id_valid) begin
         model = cleared;
         if (model.bubbles < 65535) model.bubbles++;
      end else begin
         model.valid = 1; model.rd = s.rd; model.op = s.op; model.imm = s.imm;
         model.a = operandValue(s.rs1, s.reg1, s);
         model.b = operandValue(s.rs2, s.reg2, s);
         model.rw = s.rw; model.mr = s.mr; model.mw = s.mw;
      end
      if (known) exQ.push_back(model);
   endtask

   // Registered outputs, compared just after each rising edge.
   initial begin
      ex_model_t e;
      forever begin
         @(posedge clock);
         #1;
         if (exQ.size() > 0) begin
            e = exQ.pop_front();
            checkOutput("ex_valid", {31'b0, ex_valid}, {31'b0, e.valid});
            checkOutput("ex_rd", {28'b0, ex_rd}, {28'b0, e.rd});
            checkOutput("ex_op", {28'b0, ex_op}, {28'b0, e.op});
            checkOutput("ex_a", {16'b0, ex_a}, {16'b0, e.a});
            checkOutput("ex_b", {16'b0, ex_b}, {16'b0, e.b});
            checkOutput("ex_imm", {16'b0, ex_imm}, {16'b0, e.imm});
            checkOutput("ex_ctrl", {29'b0, ex_regwrite, ex_memread, ex_memwrite}, {29'b0, e.rw, e.mr, e.mw});
`ifdef ID_EX_STATS_EN
            checkOutput("bubble_count", {16'b0, bubble_count}, e.bubbles);
            checkOutput("hold_count", {16'b0, hold_count}, e.holds);
`endif
         end
      end
   end

   // Combinational outputs, compared mid-cycle once the driven inputs have settled.
   initial begin
      comb_exp_t c;
      forever begin
         @(negedge clock);
         #3;
         if (combQ.size() > 0) begin
            c = combQ.pop_front();
            checkOutput("hazard", {31'b0, hazard}, {31'b0, c.hazard});
            checkOutput("id_ready", {31'b0, id_ready}, {31'b0, c.ready});
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic afterEdge();
      @(posedge clock);
      #2;
   endtask

   initial begin
      stim_t s;
      s = idle(); s.reset = 1;
      applyStimulus(s);
      applyStimulus(s);

      // Plain capture, no forwarding.
      s = idle(); s.id_valid = 1; s.rs1 = 3; s.reg1 = 16'h0011; s.rs2 = 4; s.reg2 = 16'h0022;
      s.use1 = 1; s.use2 = 1; s.rd = 1; s.op = 4'h2; s.imm = 16'h0005; s.rw = 1;
      applyStimulus(s);
      afterEdge();
      checkOutput("spot capture valid", {31'b0, ex_valid}, 32'd1);
      checkOutput("spot capture a", {16'b0, ex_a}, 32'h0011);
      checkOutput("spot capture b", {16'b0, ex_b}, 32'h0022);

      // EX forwarding beats MEM; register 0 never forwards.
      s = idle(); s.id_valid = 1; s.rs1 = 5; s.reg1 = 16'h7777; s.use1 = 1;
      s.fwd_ex_rd = 5; s.fwd_ex_rw = 1; s.fwd_ex_res = 16'hBEEF;
      s.fwd_mem_rd = 5; s.fwd_mem_rw = 1; s.fwd_mem_res = 16'h1234;
      applyStimulus(s);
      afterEdge();
      checkOutput("spot fwd ex", {16'b0, ex_a}, 32'hBEEF);
      s.rs1 = 0; s.fwd_ex_rd = 0; s.fwd_mem_rd = 0;
      applyStimulus(s);
      afterEdge();
      checkOutput("spot fwd r0", {16'b0, ex_a}, 32'h0000);

      // Load-use hazard, then the retried instruction picks the load data up from MEM.
      s = idle(); s.id_valid = 1; s.rd = 2; s.mr = 1; s.rw = 1;
      applyStimulus(s);
      s = idle(); s.id_valid = 1; s.rs2 = 2; s.use2 = 1; s.reg2 = 16'h5555; s.rd = 6; s.rw = 1;
      applyStimulus(s);
      #1;
      checkOutput("spot hazard", {31'b0, hazard}, 32'd1);
      checkOutput("spot hazard ready", {31'b0, id_ready}, 32'd0);
      afterEdge();
      checkOutput("spot bubble", {31'b0, ex_valid}, 32'd0);
      s.fwd_mem_rd = 2; s.fwd_mem_rw = 1; s.fwd_mem_res = 16'h00AA;
      applyStimulus(s);
      afterEdge();
      checkOutput("spot retry b", {16'b0, ex_b}, 32'h00AA);

      // Hold for three cycles with a flush in the middle.
      s = idle(); s.id_valid = 1; s.rs1 = 3; s.reg1 = 16'h1357; s.rd = 7; s.rw = 1;
      applyStimulus(s);
      for (int i = 0; i < 3; i++) begin
         s = idle(); s.hold = 1; s.id_valid = 1; s.reg1 = 16'hFFFF; s.rs1 = 1; s.flush = (i == 1);
         applyStimulus(s);
         afterEdge();
         checkOutput("spot hold a", {16'b0, ex_a}, 32'h1357);
         checkOutput("spot hold valid", {31'b0, ex_valid}, 32'd1);
      end

      // Flush kills the incoming instruction but decode is still accepted.
      s = idle(); s.id_valid = 1; s.rw = 1; s.flush = 1; s.rd = 3;
      applyStimulus(s);
      #1;
      checkOutput("spot flush ready", {31'b0, id_ready}, 32'd1);
      afterEdge();
      checkOutput("spot flush ctrl", {30'b0, ex_valid, ex_regwrite}, 32'd0);

      // Reset while holding a valid instruction.
      s = idle(); s.id_valid = 1; s.rs1 = 3; s.reg1 = 16'h00F0; s.rd = 4; s.rw = 1; s.mr = 1;
      applyStimulus(s);
      s = idle(); s.reset = 1; s.hold = 1; s.id_valid = 1; s.rs1 = 4; s.use1 = 1;
      applyStimulus(s);
      afterEdge();
      checkOutput("spot reset valid", {31'b0, ex_valid}, 32'd0);
      checkOutput("spot reset a", {16'b0, ex_a}, 32'd0);
      checkOutput("spot reset hazard", {31'b0, hazard}, 32'd0);

      // Randomised traffic over a small register range so hazards and forwards collide often.
      for (int n = 0; n < 600; n++) begin
         s.reset = ($urandom_range(0, 99) < 2);
         s.id_valid = ($urandom_range(0, 99) < 80);
         s.hold = ($urandom_range(0, 99) < 20);
         s.flush = ($urandom_range(0, 99) < 12);
         s.rs1 = 4'($urandom_range(0, 3)); s.rs2 = 4'($urandom_range(0, 3));
         s.rd = 4'($urandom_range(0, 3)); s.op = 4'($urandom);
         s.use1 = 1'($urandom); s.use2 = 1'($urandom);
         s.rw = 1'($urandom); s.mr = 1'($urandom); s.mw = 1'($urandom);
         s.reg1 = 16'($urandom); s.reg2 = 16'($urandom); s.imm = 16'($urandom);
         s.fwd_ex_rd = 4'($urandom_range(0, 3)); s.fwd_ex_rw = 1'($urandom); s.fwd_ex_res = 16'($urandom);
         s.fwd_mem_rd = 4'($urandom_range(0, 3)); s.fwd_mem_rw = 1'($urandom); s.fwd_mem_res = 16'($urandom);
         applyStimulus(s);
      end

      applyStimulus(idle());
      repeat (3) @(posedge clock);
      #4;
      checkOutput("scoreboard ex drained", exQ.size(), 32'd0);
      checkOutput("scoreboard comb drained", combQ.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
